// File: rtl/tx_sample_scheduler.sv
// TX sample scheduler: holds each burst until its send_time, plays 32-bit halves on DAC strobes, reports ACK/late/underrun/sequence errors.
// Optional first-word sequence check is compiled in with `define TX_SCHED_SEQ_CHECK_EN.
module tx_sample_scheduler #(
    parameter bit ERR_ON_LATE = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic [63:0]  vita_time,
    input  logic         strobe,
    input  logic [175:0] sample_tdata,
    input  logic         sample_tvalid,
    output logic         sample_tready,
    output logic [31:0]  tx_sample,
    output logic         run,
    output logic [63:0]  err_tdata,
    output logic         err_tvalid,
    input  logic         err_tready,
    output logic [15:0]  err_drops,
    output logic [1:0]   state_dbg
);
    // Handshakes: a word or error moves on a rising clk edge where valid and
    // ready are both high; valid never waits for ready, and sample_tready is
    // asserted only in the cycle the head word is retired.

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RUN = 2'd2, DUMP = 2'd3} state_t;

    localparam logic [7:0] CODE_ACK      = 8'h01;
    localparam logic [7:0] CODE_UNDERRUN = 8'h02;
    localparam logic [7:0] CODE_SEQ_ERR  = 8'h04;
    localparam logic [7:0] CODE_LATE     = 8'h08;
    localparam logic       HI            = 1'b0;
    localparam logic       LO            = 1'b1;

    logic        w_odd, w_send_at, w_eob, w_last;
    logic [11:0] w_seqnum;
    logic [31:0] w_sid;
    logic [63:0] w_send_time, w_data;

    assign w_odd       = sample_tdata[175];
    assign w_send_at   = sample_tdata[174];
    assign w_eob       = sample_tdata[173];
    assign w_last      = sample_tdata[172];
    assign w_seqnum    = sample_tdata[171:160];
    assign w_sid       = sample_tdata[159:128];
    assign w_send_time = sample_tdata[127:64];
    assign w_data      = sample_tdata[63:0];

    state_t      state, state_n;
    logic        half, half_n;
    logic        first, first_n;
    logic [11:0] seq_q;
    logic [31:0] sid_q;
    logic        first_tick;
    logic        seq_err;
    logic        play, blank;
    logic        post;
    logic [7:0]  post_code;
    logic [11:0] post_seq;
    logic [31:0] post_sid;

    assign state_dbg  = state;
    assign first_tick = first && sample_tvalid && (state != WAIT);

`ifdef TX_SCHED_SEQ_CHECK_EN
    logic [11:0] exp_seq;

    // Dumped packets still advance the expectation so a later burst is not flagged.
    assign seq_err = first_tick && (state != DUMP) && (w_seqnum != exp_seq);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_seq <= '0;
        end else if (clear) begin
            exp_seq <= '0;
        end else if (first_tick) begin
            exp_seq <= w_seqnum + 12'd1;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

    always_comb begin
        state_n       = state;
        half_n        = half;
        first_n       = first;
        sample_tready = 1'b0;
        play          = 1'b0;
        blank         = 1'b0;
        post          = 1'b0;
        post_code     = CODE_ACK;
        post_seq      = seq_q;
        post_sid      = sid_q;

        if (first_tick) first_n = 1'b0;

        case (state)
            IDLE: begin
                blank = strobe;
                if (first_tick) begin
                    if (seq_err) begin
                        post      = 1'b1;
                        post_code = CODE_SEQ_ERR;
                        post_seq  = w_seqnum;
                        post_sid  = w_sid;
                        state_n   = DUMP;
                    end else if (w_send_at) begin
                        state_n = WAIT;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            WAIT: begin
                if (strobe) begin
                    if (sample_tvalid && (vita_time == w_send_time)) begin
                        play = 1'b1;
                    end else if (sample_tvalid && (vita_time > w_send_time)) begin
                        if (ERR_ON_LATE) begin
                            post      = 1'b1;
                            post_code = CODE_LATE;
                            state_n   = DUMP;
                            blank     = 1'b1;
                        end else begin
                            play = 1'b1;
                        end
                    end else begin
                        blank = 1'b1;
                    end
                end
            end
            RUN: begin
                if (seq_err) begin
                    post      = 1'b1;
                    post_code = CODE_SEQ_ERR;
                    post_seq  = w_seqnum;
                    post_sid  = w_sid;
                    state_n   = DUMP;
                    blank     = strobe;
                end else if (strobe) begin
                    if (!sample_tvalid) begin
                        post      = 1'b1;
                        post_code = CODE_UNDERRUN;
                        state_n   = DUMP;
                        half_n    = HI;
                        blank     = 1'b1;
                    end else begin
                        play = 1'b1;
                    end
                end
            end
            DUMP: begin
                blank         = strobe;
                sample_tready = sample_tvalid;
                if (sample_tvalid && w_last) first_n = 1'b1;
                if (sample_tvalid && w_last && w_eob) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // A single-sample final word (last & odd) retires after its HI half.
        if (play) begin
            if ((half == LO) || (w_last && w_odd)) begin
                sample_tready = 1'b1;
                half_n        = HI;
                if (w_last) first_n = 1'b1;
                if (w_last && w_eob) begin
                    post      = 1'b1;
                    post_code = CODE_ACK;
                    state_n   = IDLE;
                end else begin
                    state_n = RUN;
                end
            end else begin
                half_n  = LO;
                state_n = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            half      <= HI;
            first     <= 1'b1;
            seq_q     <= '0;
            sid_q     <= '0;
            tx_sample <= '0;
            run       <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            half      <= HI;
            first     <= 1'b1;
            seq_q     <= '0;
            sid_q     <= '0;
            tx_sample <= '0;
            run       <= 1'b0;
        end else begin
            state <= state_n;
            half  <= half_n;
            first <= first_n;
            if (first_tick) begin
                seq_q <= w_seqnum;
                sid_q <= w_sid;
            end
            if (play) begin
                tx_sample <= (half == LO) ? w_data[31:0] : w_data[63:32];
                run       <= 1'b1;
            end else if (blank) begin
                tx_sample <= '0;
                run       <= 1'b0;
            end
        end
    end

    // Single-entry error holding register; a same-cycle accept frees it for the new word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_tvalid <= 1'b0;
            err_tdata  <= '0;
            err_drops  <= '0;
        end else if (clear) begin
            err_tvalid <= 1'b0;
            err_tdata  <= '0;
            err_drops  <= '0;
        end else if (post) begin
            if (!err_tvalid || err_tready) begin
                err_tvalid <= 1'b1;
                err_tdata  <= {post_code, 12'd0, post_seq, post_sid};
            end else if (err_drops != 16'hFFFF) begin
                err_drops <= err_drops + 16'd1;
            end
        end else if (err_tready) begin
            err_tvalid <= 1'b0;
        end
    end

endmodule
